spike_rate_encoder: RTL and testbench
=====================================

Name: spike_rate_encoder

Overview:
- Front end of the SNN. Converts a frame of six unsigned input intensities into deterministic rate-coded spike trains.
- spk_out[0..5] drive the network inputs inp_1..inp_6 respectively.
- Each frame is presented for a fixed window. The encoder then holds a rest period and pulses net_reset so neuron membrane potentials clear before the next frame.
- Frames are accepted through a valid/ready handshake.

Parameters:
- NUM_CH, 6: number of input channels/spike lines.
- INT_W, 8: intensity width (unsigned).
- WINDOW, 64: presentation window length in clock cycles (>=1).
- REST_CYCLES, 8: cycles net_reset is held high after a window (>=1).

Ports:
- clock  in  1  system clock, all logic on posedge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  frame intensities valid.
- in_ready  out  1  encoder can accept a frame (high only in IDLE).
- in_data  in  NUM_CH*INT_W  intensities; channel k at bits [k*INT_W +: INT_W].
- abort  in  1  terminate current window early.
- spk_out  out  NUM_CH  registered spike lines, bit k -> inp_(k+1).
- window_active  out  1  registered; high in cycles where spk_out is valid window output.
- net_reset  out  1  registered; drives neuron reset during rest.
- done  out  1  one-cycle pulse when the frame completes (normal or aborted).

Behaviour:
- Reset (clock/reset as above; sync, active-high): state=IDLE, counters=0, accumulators=0, latched intensities=0.
  - Outputs after the reset edge: spk_out=0, window_active=0, net_reset=0, done=0, in_ready=1.
  - Reset in any state, including mid-window, discards the frame; no done pulse.
- States: IDLE, PRESENT, REST. in_ready = (state==IDLE), combinational from state.
- IDLE:
  - Handshake at edge E0 when in_valid & in_ready.
  - On handshake: latch in_data, clear all accumulators and cnt, go to PRESENT.
  - abort is ignored in IDLE. If abort & in_valid are both high, the handshake is still accepted.
- PRESENT, each edge E1..E_WINDOW, per channel k:
  - sum = {1'b0, acc_k} + {1'b0, int_k}, INT_W+1 bits.
  - spk_out[k] <= sum[INT_W] (carry); acc_k <= sum[INT_W-1:0].
  - window_active <= 1; cnt++.
  - At E_WINDOW (cnt==WINDOW-1): go to REST, cnt=0.
- Rate rule: spikes per window = floor(int*WINDOW/256) for INT_W=8 starting from acc=0.
  - 0 gives no spikes; 255 gives WINDOW-1 spikes.
  - The first-cycle spike is impossible.
- in_valid during PRESENT/REST is not accepted (in_ready=0). The source holds data; no overflow or loss.
- abort sampled high at an edge in PRESENT:
  - That edge: go to REST, spk_out<=0, window_active<=0, accumulators frozen.
  - Rest timing then proceeds exactly as after a normal window.
  - abort in REST is ignored.
- REST:
  - First REST edge: spk_out<=0, window_active<=0, net_reset<=1.
  - net_reset stays high for exactly REST_CYCLES cycles (cnt counts REST edges).
  - The last spike of the window is therefore sampled by the network at the edge before net_reset rises.
  - On the edge ending REST: net_reset<=0, done<=1, go to IDLE.
- done:
  - Normal frame: pulses in the cycle after edge E0+WINDOW+REST_CYCLES+1 (E73 with defaults).
  - It coincides with in_ready=1, so a new frame may be accepted in the done cycle (back-to-back).
- Widths: acc INT_W bits, wraps modulo 2^INT_W. cnt width = clog2(max(WINDOW, REST_CYCLES+1)). All unsigned.

Decomposition:
- Shared package snn_pkg: NUM_CH, INT_W defaults; enc_state_t enum {IDLE, PRESENT, REST}; default WINDOW/REST_CYCLES constants shared with the output decoder.
- One sub-module, spike_phase_acc: per-channel accumulator.
  - Inputs: clock, reset, clear, enable, intensity.
  - Output: carry/spike.
  - Instantiated NUM_CH times by generate.

Test Plan:
- Reset, frame with all intensities 0:
  - spk_out stays 0.
  - window_active high 64 cycles.
  - net_reset high 8 cycles.
  - done pulse at E0+73.
  - in_ready returns 1.
- ch0=128, others 0:
  - spk_out[0] pulses on window cycles 2,4,...,64 (32 spikes).
  - All other bits 0.
- ch5=255, ch1=4, ch2=1:
  - ch5 has 63 spikes, silent only on window cycle 1.
  - ch1 has exactly one spike, on window cycle 64.
  - ch2 has 0 spikes.
- in_valid held high continuously with two different frames:
  - Second frame accepted in the done cycle of the first.
  - Its spike pattern starts from acc=0, with no carry-over from the first frame.
- abort at window cycle 10:
  - spk_out=0 and window_active=0 from the next cycle.
  - net_reset high 8 cycles, then done pulse.
  - abort asserted again in REST has no effect.
- reset asserted mid-PRESENT (cycle 30, ch0=128):
  - Next cycle all outputs 0, in_ready=1, no done pulse.
  - A new frame behaves identically to a fresh one.

Source files
------------

// File: rtl/snn_pkg.sv
// Shared SNN constants and types used by the spike encoder and the output decoder.
package snn_pkg;

    localparam int unsigned NUM_CH           = 6;
    localparam int unsigned INT_W            = 8;
    localparam int unsigned DEF_WINDOW       = 64;
    localparam int unsigned DEF_REST_CYCLES  = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESENT = 2'd1,
        REST    = 2'd2
    } enc_state_t;

    // Counter must reach WINDOW-1 while presenting and REST_CYCLES while resting.
    function automatic int unsigned cnt_width(input int unsigned window, input int unsigned rest);
        int unsigned m;
        m = (window > rest + 1) ? window : rest + 1;
        return (m <= 1) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/spike_phase_acc.sv
// Per-channel phase accumulator; the carry out of acc+intensity is the spike.
module spike_phase_acc
    import snn_pkg::*;
#(
    parameter int unsigned ACC_W = INT_W
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clear,
    input  logic             enable,
    input  logic [ACC_W-1:0] intensity,
    output logic             spike_c
);

    logic [ACC_W-1:0] acc_q;
    logic [ACC_W-1:0] acc_d;
    logic [ACC_W:0]   sum;

    always_comb begin
        sum   = {1'b0, acc_q} + {1'b0, intensity};
        acc_d = acc_q;
        if (clear) begin
            acc_d = '0;
        end else if (enable) begin
            acc_d = sum[ACC_W-1:0];
        end
    end

    assign spike_c = sum[ACC_W];

    always_ff @(posedge clock) begin
        if (reset) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

endmodule

// File: rtl/spike_rate_encoder.sv
// Rate-codes a frame of intensities into spike trains for a fixed window, then
// holds net_reset through a rest period before accepting the next frame.
module spike_rate_encoder
    import snn_pkg::*;
#(
    parameter int unsigned CH          = NUM_CH,
    parameter int unsigned IW          = INT_W,
    parameter int unsigned WINDOW      = DEF_WINDOW,
    parameter int unsigned REST_CYCLES = DEF_REST_CYCLES
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [CH*IW-1:0] in_data,
    input  logic             abort,
    output logic [CH-1:0]    spk_out,
    output logic             window_active,
    output logic             net_reset,
    output logic             done
);

    localparam int unsigned CNT_W = cnt_width(WINDOW, REST_CYCLES);

    enc_state_t               state_q, state_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic [CH-1:0][IW-1:0]    int_q, int_d;
    logic [CH-1:0]            spk_q, spk_d;
    logic                     wa_q, wa_d;
    logic                     nr_q, nr_d;
    logic                     done_q, done_d;
    logic                     acc_clear;
    logic                     acc_en;
    logic [CH-1:0]            carry;

    for (genvar k = 0; k < CH; k++) begin : g_acc
        spike_phase_acc #(.ACC_W(IW)) u_acc (
            .clock     (clock),
            .reset     (reset),
            .clear     (acc_clear),
            .enable    (acc_en),
            .intensity (int_q[k]),
            .spike_c   (carry[k])
        );
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        int_d     = int_q;
        spk_d     = '0;
        wa_d      = 1'b0;
        nr_d      = 1'b0;
        done_d    = 1'b0;
        acc_clear = 1'b0;
        acc_en    = 1'b0;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    int_d     = in_data;
                    acc_clear = 1'b1;
                    cnt_d     = '0;
                    state_d   = PRESENT;
                end
            end
            PRESENT: begin
                // Abort freezes the accumulators and drops straight into rest.
                if (abort) begin
                    cnt_d   = '0;
                    state_d = REST;
                end else begin
                    acc_en = 1'b1;
                    spk_d  = carry;
                    wa_d   = 1'b1;
                    if (cnt_q == CNT_W'(WINDOW - 1)) begin
                        cnt_d   = '0;
                        state_d = REST;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            REST: begin
                if (cnt_q == CNT_W'(REST_CYCLES)) begin
                    done_d  = 1'b1;
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    nr_d  = 1'b1;
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            int_q   <= '0;
            spk_q   <= '0;
            wa_q    <= 1'b0;
            nr_q    <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            int_q   <= int_d;
            spk_q   <= spk_d;
            wa_q    <= wa_d;
            nr_q    <= nr_d;
            done_q  <= done_d;
        end
    end

    assign in_ready      = (state_q == IDLE);
    assign spk_out       = spk_q;
    assign window_active = wa_q;
    assign net_reset     = nr_q;
    assign done          = done_q;

endmodule

// File: tb/tb_spike_rate_encoder.sv
// Randomized bench for spike_rate_encoder against a closed-form rate/timing model.
module tb_spike_rate_encoder;

    localparam int unsigned NC = 6;
    localparam int unsigned IW = 8;
    localparam int unsigned W  = 64;
    localparam int unsigned R  = 8;

    logic             clock;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    logic [NC*IW-1:0] in_data;
    logic             abort;
    logic [NC-1:0]    spk_out;
    logic             window_active;
    logic             net_reset;
    logic             done;

    int checks   = 0;
    int failures = 0;

    spike_rate_encoder #(
        .CH(NC), .IW(IW), .WINDOW(W), .REST_CYCLES(R)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_data       (in_data),
        .abort         (abort),
        .spk_out       (spk_out),
        .window_active (window_active),
        .net_reset     (net_reset),
        .done          (done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check_outs(input string ph, input logic [NC-1:0] e_spk, input logic e_wa,
                              input logic e_nr, input logic e_done, input logic e_rdy);
        chk({ph, ".spk_out"}, 32'(spk_out), 32'(e_spk));
        chk({ph, ".window_active"}, 32'(window_active), 32'(e_wa));
        chk({ph, ".net_reset"}, 32'(net_reset), 32'(e_nr));
        chk({ph, ".done"}, 32'(done), 32'(e_done));
        chk({ph, ".in_ready"}, 32'(in_ready), 32'(e_rdy));
    endtask

    // Spike on window cycle n iff floor(n*v/2^IW) steps up from floor((n-1)*v/2^IW).
    function automatic logic [NC-1:0] exp_spk(input logic [NC*IW-1:0] d, input int n);
        logic [NC-1:0] e;
        for (int k = 0; k < int'(NC); k++) begin
            int v;
            v    = int'(d[k*IW +: IW]);
            e[k] = ((n * v) >> IW) != (((n - 1) * v) >> IW);
        end
        return e;
    endfunction

    function automatic logic [NC*IW-1:0] rand_frame();
        return (NC*IW)'({$urandom(), $urandom()});
    endfunction

    // Presents one frame starting in an IDLE cycle; returns in its done cycle (or after a reset).
    task automatic run_frame(input logic [NC*IW-1:0] data, input int abort_at, input bit rest_abort,
                             input int rst_at, input bit hold, input logic [NC*IW-1:0] next_data);
        int rest_start;
        int spk_cnt[NC];
        logic [NC-1:0] e;
        for (int k = 0; k < int'(NC); k++) spk_cnt[k] = 0;
        rest_start = (abort_at > 0) ? abort_at + 1 : int'(W) + 1;

        chk("ready_before_frame", 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        in_data  = data;
        abort    = 1'($urandom_range(0, 1));
        step();
        check_outs("accept", '0, 1'b0, 1'b0, 1'b0, 1'b0);
        abort = 1'b0;
        if (hold) in_data = next_data;
        else      in_valid = 1'b0;

        for (int j = 1; j <= rest_start + int'(R); j++) begin
            abort = (j == abort_at) || (rest_abort && j >= rest_start && j < rest_start + 4);
            reset = (j == rst_at);
            if (!hold) begin
                in_valid = 1'($urandom_range(0, 1));
                in_data  = rand_frame();
            end
            step();
            abort = 1'b0;
            reset = 1'b0;
            if (j == rst_at) begin
                in_valid = 1'b0;
                check_outs("after_reset", '0, 1'b0, 1'b0, 1'b0, 1'b1);
                step();
                check_outs("post_reset_idle", '0, 1'b0, 1'b0, 1'b0, 1'b1);
                return;
            end
            if (j >= rest_start + int'(R)) begin
                check_outs("done_cycle", '0, 1'b0, 1'b0, 1'b1, 1'b1);
            end else if (j >= rest_start) begin
                check_outs("rest", '0, 1'b0, 1'b1, 1'b0, 1'b0);
            end else if (j == abort_at) begin
                check_outs("abort_gap", '0, 1'b0, 1'b0, 1'b0, 1'b0);
            end else begin
                e = exp_spk(data, j);
                check_outs("window", e, 1'b1, 1'b0, 1'b0, 1'b0);
                for (int k = 0; k < int'(NC); k++) spk_cnt[k] += int'(spk_out[k]);
            end
        end

        if (abort_at == 0) begin
            for (int k = 0; k < int'(NC); k++)
                chk($sformatf("spike_total_ch%0d", k), 32'(spk_cnt[k]),
                    32'((int'(W) * int'(data[k*IW +: IW])) / (1 << IW)));
        end
        if (!hold) in_valid = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        in_valid = 1'b0;
        for (int i = 0; i < n; i++) begin
            abort = 1'($urandom_range(0, 1));
            step();
            check_outs("idle", '0, 1'b0, 1'b0, 1'b0, 1'b1);
        end
        abort = 1'b0;
    endtask

    initial begin
        logic [NC*IW-1:0] fa, fb;
        reset    = 1'b1;
        in_valid = 1'b0;
        abort    = 1'b0;
        in_data  = '0;
        step();
        step();
        check_outs("reset", '0, 1'b0, 1'b0, 1'b0, 1'b1);
        reset = 1'b0;
        idle_cycles(2);

        run_frame('0, 0, 1'b0, 0, 1'b0, '0);
        idle_cycles(1);
        run_frame((NC*IW)'(128), 0, 1'b0, 0, 1'b0, '0);
        idle_cycles(3);
        run_frame({8'd255, 8'd0, 8'd0, 8'd1, 8'd4, 8'd0}, 0, 1'b0, 0, 1'b0, '0);

        fa = rand_frame();
        fb = rand_frame();
        run_frame(fa, 0, 1'b0, 0, 1'b1, fb);
        run_frame(fb, 0, 1'b0, 0, 1'b0, '0);
        idle_cycles(2);

        run_frame(rand_frame(), 11, 1'b1, 0, 1'b0, '0);
        idle_cycles(1);
        run_frame((NC*IW)'(128), 0, 1'b0, 30, 1'b0, '0);
        run_frame((NC*IW)'(128), 0, 1'b0, 0, 1'b0, '0);

        for (int f = 0; f < 6; f++) begin
            int ab;
            ab = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, W)) : 0;
            run_frame(rand_frame(), ab, 1'($urandom_range(0, 1)), 0, 1'b0, '0);
            idle_cycles(int'($urandom_range(0, 3)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
